i2c_tmp101_responder: RTL

//  I2C slave that emulates a TMP101 sensor, for bench and board self-test of the Lab7 I2C read master.

---
 rtl/i2c_tmp101_responder_if.sv | 11 +
 rtl/i2c_tmp101_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_tmp101_responder_if.sv
`timescale 1ns/1ps
// I2C bus as seen by the TMP101 responder: SCL input, resolved SDA level, open-drain pull-down request.
// sda_drive_low=1 pulls SDA low; 0 leaves SDA to the pull-up (Z).
interface i2c_tmp101_responder_if;
    logic scl;
    logic sda;
    logic sda_drive_low;

    modport master (output scl, output sda, input sda_drive_low);
    modport slave  (input scl, input sda, output sda_drive_low);
endinterface

// File: rtl/i2c_tmp101_responder.sv
`timescale 1ns/1ps
// TMP101-style I2C responder: answers {4'b1001,DeviceAddress}, returns a 12-bit temperature as two bytes.
// Define TMP101_PTR_WRITE_EN to accept pointer/config writes; otherwise write addresses are NACKed.
module i2c_tmp101_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                   clock,
    input  logic                   Reset,
    input  logic [2:0]             DeviceAddress,
    input  logic [11:0]            Temperature,
    i2c_tmp101_responder_if.slave  bus,
    output logic                   Busy,
    output logic                   AddressMatch,
    output logic                   ReadDone,
    output logic [7:0]             ConfigOut
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, TX_BYTE, TX_ACK,
        RX_PTR, RX_PTR_ACK, RX_DATA, RX_DATA_ACK, WAIT_STOP
    } state_t;

    localparam int HCW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
`ifdef TMP101_PTR_WRITE_EN
    localparam bit WRITE_EN = 1'b1;
`else
    localparam bit WRITE_EN = 1'b0;
`endif

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;
    logic [2:0]             bit_cnt_q;
    logic [6:0]             shift_q;
    logic                   rw_q, byte_sel_q;
    logic [15:0]            tx_word_q;
    logic [7:0]             tx_byte;
    logic                   drive_q, pend_q, drive_d;
    logic [HCW-1:0]         hold_cnt_q;
    logic                   busy_q, addr_match_q, read_done_q;
    logic [1:0]             ptr;
    logic [7:0]             cfg;

`ifdef TMP101_PTR_WRITE_EN
    logic [1:0] ptr_q;
    logic [7:0] cfg_q;
    logic [7:0] rx_byte_q;
    assign ptr = ptr_q;
    assign cfg = cfg_q;
`else
    assign ptr = 2'b00;
    assign cfg = 8'h00;
`endif

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    // Drive level for the bit that starts at the current SCL fall.
    always_comb begin
        tx_byte = byte_sel_q ? tx_word_q[7:0] : tx_word_q[15:8];
        if (ptr == 2'b01) begin
            tx_byte = cfg;
        end
        drive_d = 1'b0;
        case (state_q)
            ADDR_ACK, RX_PTR_ACK, RX_DATA_ACK: drive_d = 1'b1;
            TX_BYTE:                           drive_d = ~tx_byte[3'd7 - bit_cnt_q];
            default:                           drive_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!Reset) begin
            scl_sync_q   <= '1;
            sda_sync_q   <= '1;
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 7'd0;
            rw_q         <= 1'b0;
            byte_sel_q   <= 1'b0;
            tx_word_q    <= 16'h0000;
            drive_q      <= 1'b0;
            pend_q       <= 1'b0;
            hold_cnt_q   <= '0;
            busy_q       <= 1'b0;
            addr_match_q <= 1'b0;
            read_done_q  <= 1'b0;
`ifdef TMP101_PTR_WRITE_EN
            ptr_q        <= 2'b00;
            cfg_q        <= 8'h00;
            rx_byte_q    <= 8'h00;
`endif
        end else begin
            scl_sync_q   <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl};
            sda_sync_q   <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda};
            scl_prev_q   <= scl_s;
            sda_prev_q   <= sda_s;
            addr_match_q <= 1'b0;
            read_done_q  <= 1'b0;

            if (hold_cnt_q != '0) begin
                hold_cnt_q <= hold_cnt_q - 1'b1;
                if (hold_cnt_q == HCW'(1)) begin
                    drive_q <= pend_q;
                end
            end

            if (start_det) begin
                state_q    <= ADDR;
                bit_cnt_q  <= 3'd0;
                busy_q     <= 1'b1;
                drive_q    <= 1'b0;
                hold_cnt_q <= '0;
            end else if (stop_det) begin
                state_q    <= IDLE;
                busy_q     <= 1'b0;
                drive_q    <= 1'b0;
                hold_cnt_q <= '0;
            end else if (scl_fall) begin
                if (HOLD_CYCLES == 0) begin
                    drive_q <= drive_d;
                end else begin
                    pend_q     <= drive_d;
                    hold_cnt_q <= HCW'(HOLD_CYCLES);
                end
            end else if (scl_rise) begin
                case (state_q)
                    ADDR, RX_PTR, RX_DATA: begin
                        shift_q   <= {shift_q[5:0], sda_s};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ADDR) begin
                                rw_q    <= sda_s;
                                state_q <= (shift_q == {4'b1001, DeviceAddress} && (sda_s || WRITE_EN))
                                           ? ADDR_ACK : WAIT_STOP;
                            end else begin
                                state_q <= (state_q == RX_PTR) ? RX_PTR_ACK : RX_DATA_ACK;
                            end
`ifdef TMP101_PTR_WRITE_EN
                            rx_byte_q <= {shift_q, sda_s};
`endif
                        end
                    end
                    ADDR_ACK: begin
                        // Snapshot both bytes together so a read never mixes two samples.
                        addr_match_q <= 1'b1;
                        tx_word_q    <= {Temperature, 4'b0000};
                        byte_sel_q   <= 1'b0;
                        state_q      <= rw_q ? TX_BYTE : RX_PTR;
                    end
                    TX_BYTE: begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= TX_ACK;
                        end
                    end
                    TX_ACK: begin
                        if (!sda_s) begin
                            byte_sel_q <= ~byte_sel_q;
                            state_q    <= TX_BYTE;
                        end else begin
                            read_done_q <= 1'b1;
                            state_q     <= WAIT_STOP;
                        end
                    end
                    RX_PTR_ACK: begin
`ifdef TMP101_PTR_WRITE_EN
                        ptr_q <= rx_byte_q[1:0];
`endif
                        state_q <= RX_DATA;
                    end
                    RX_DATA_ACK: begin
`ifdef TMP101_PTR_WRITE_EN
                        if (ptr_q == 2'b01) begin
                            cfg_q <= rx_byte_q;
                        end
`endif
                        state_q <= RX_DATA;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.sda_drive_low = drive_q;
    assign Busy              = busy_q;
    assign AddressMatch      = addr_match_q;
    assign ReadDone          = read_done_q;
    assign ConfigOut         = cfg;
endmodule
